// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int PIPE_XLEN   = 64;
  localparam int PIPE_REG_AW = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    WAIT_IF = 1'b1
  } state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : saturating up-counter with synchronous active-low clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush/redirect sequencing for the 5-stage pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN   = PIPE_XLEN,
  parameter int REG_AW = PIPE_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_vec,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              memwb_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redirect_cnt
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pend_pc, pend_nxt;
  stage_ctrl_t     ifid, idex, exmem, memwb;
  logic            load_use;

  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt      = state;
    pend_nxt       = pend_pc;
    pc_stall       = 1'b0;
    ifid           = '0;
    idex           = '0;
    exmem          = '0;
    memwb          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (!rstn) begin
      ifid.flush  = 1'b1;
      idex.flush  = 1'b1;
      exmem.flush = 1'b1;
      memwb.flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (trap_req) begin
            ifid.flush  = 1'b1;
            idex.flush  = 1'b1;
            exmem.flush = 1'b1;
            memwb.flush = 1'b1;
            if (if_busy) begin
              pend_nxt  = trap_vec;
              state_nxt = WAIT_IF;
              pc_stall  = 1'b1;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = trap_vec;
            end
          end else if (mem_busy) begin
            // EX keeps any pending branch until the data access completes
            pc_stall    = 1'b1;
            ifid.stall  = 1'b1;
            idex.stall  = 1'b1;
            exmem.stall = 1'b1;
            memwb.flush = 1'b1;
          end else if (ex_redirect) begin
            ifid.flush = 1'b1;
            idex.flush = 1'b1;
            if (if_busy) begin
              pend_nxt  = ex_target;
              state_nxt = WAIT_IF;
              pc_stall  = 1'b1;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = ex_target;
            end
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid.stall = 1'b1;
            idex.flush = 1'b1;
          end else if (if_busy) begin
            pc_stall   = 1'b1;
            ifid.flush = 1'b1;
          end
        end

        WAIT_IF: begin
          // The in-flight fetch belongs to the old path, so IFID is always cleared
          pc_stall   = 1'b1;
          ifid.flush = 1'b1;
          if (trap_req) begin
            idex.flush  = 1'b1;
            exmem.flush = 1'b1;
            memwb.flush = 1'b1;
          end else if (mem_busy) begin
            idex.stall  = 1'b1;
            exmem.stall = 1'b1;
            memwb.flush = 1'b1;
          end
          if (!if_busy) begin
            redirect_valid = 1'b1;
            redirect_pc    = trap_req ? trap_vec : pend_pc;
            state_nxt      = RUN;
          end else if (trap_req) begin
            pend_nxt = trap_vec;
          end
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  assign ifid_stall  = ifid.stall;
  assign idex_stall  = idex.stall;
  assign exmem_stall = exmem.stall;
  assign memwb_stall = memwb.stall;
  assign ifid_flush  = ifid.flush;
  assign idex_flush  = idex.flush;
  assign exmem_flush = exmem.flush;
  assign memwb_flush = memwb.flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (redirect_valid),
    .count (redirect_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed and randomized checks of pipe_hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int  CNT_W = 32;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_busy, mem_busy;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_is_load;
  logic        ex_redirect, trap_req;
  logic [63:0] ex_target, trap_vec;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [CNT_W-1:0] stall_cycles, redirect_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state: an owed redirect and two event tallies
  bit          m_wait;
  logic [63:0] m_pend;
  longint      m_stalls, m_redirs;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(64), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .if_busy(if_busy), .mem_busy(mem_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  // {pc_stall, ifid/idex/exmem/memwb stall, ifid/idex/exmem/memwb flush, redirect_valid}
  wire [9:0] obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect_valid};

  function automatic void model_outs(output logic [9:0] v, output logic [63:0] pc);
    bit hazard;
    v  = '0;
    pc = '0;
    hazard = ex_valid && ex_is_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rstn) begin
      v[4:1] = 4'hf;
    end else if (m_wait) begin
      v[9] = 1; v[4] = 1;
      if (trap_req) v[3:1] = 3'b111;
      else if (mem_busy) begin v[7] = 1; v[6] = 1; v[1] = 1; end
      if (!if_busy) begin v[0] = 1; pc = trap_req ? trap_vec : m_pend; end
    end else if (trap_req) begin
      v[4:1] = 4'hf;
      if (if_busy) v[9] = 1; else begin v[0] = 1; pc = trap_vec; end
    end else if (mem_busy) begin
      v[9:6] = 4'hf; v[1] = 1;
    end else if (ex_redirect) begin
      v[4] = 1; v[3] = 1;
      if (if_busy) v[9] = 1; else begin v[0] = 1; pc = ex_target; end
    end else if (hazard) begin
      v[9] = 1; v[8] = 1; v[3] = 1;
    end else if (if_busy) begin
      v[9] = 1; v[4] = 1;
    end
  endfunction

  function automatic void model_update();
    logic [9:0]  v;
    logic [63:0] p;
    model_outs(v, p);
    if (!rstn) begin
      m_wait = 0; m_pend = '0; m_stalls = 0; m_redirs = 0;
    end else begin
      if (v[9] && m_stalls < MAXC) m_stalls++;
      if (v[0] && m_redirs < MAXC) m_redirs++;
      if (m_wait) begin
        if (!if_busy) m_wait = 0;
        else if (trap_req) m_pend = trap_vec;
      end else if (if_busy && (trap_req || (!mem_busy && ex_redirect))) begin
        m_wait = 1;
        m_pend = trap_req ? trap_vec : ex_target;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    if_busy = 0; mem_busy = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0; ex_target = '0;
    trap_req = 0; trap_vec = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick();
    rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0; trap_req = 1; if_busy = 1; ex_redirect = 1; mem_busy = 1; trap_vec = 64'h1234;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0000011110 || redirect_pc !== 64'h0) begin
      errors++; $display("FAIL reset_outs got %b/%h want 0000011110/0", obs, redirect_pc);
    end
    tick();
    idle_inputs();
    rstn = 1;
    checks++;
    if (stall_cycles !== 0 || redirect_cnt !== 0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, redirect_cnt);
    end
    @(negedge clk);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL reset_idle got %b want 0", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b1100001000) begin
      errors++; $display("FAIL load_use got %b want 1100001000", obs);
    end
    tick();
    ex_valid = 0; ex_is_load = 0;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL load_use_bubble got %b want 0", obs);
    end
    checks++;
    if (stall_cycles !== 1) begin
      errors++; $display("FAIL load_use_count got %0d want 1", stall_cycles);
    end
    tick();
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL load_x0 got %b want 0", obs);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_redirect = 1; ex_target = 64'h80000100;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0000011001 || redirect_pc !== 64'h80000100) begin
      errors++; $display("FAIL branch_idle got %b/%h want 0000011001/80000100", obs, redirect_pc);
    end
    tick();
    ex_redirect = 0;
    checks++;
    if (redirect_cnt !== 1) begin
      errors++; $display("FAIL branch_count got %0d want 1", redirect_cnt);
    end
  endtask

  task automatic test_branch_fetch();
    do_reset();
    ex_redirect = 1; ex_target = 64'h80000100; if_busy = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b1000011000) begin
      errors++; $display("FAIL branch_fetch_first got %b want 1000011000", obs);
    end
    tick();
    ex_redirect = 0; ex_target = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 10'b1000010000) begin
        errors++; $display("FAIL branch_fetch_wait%0d got %b want 1000010000", i, obs);
      end
      tick();
    end
    if_busy = 0;
    @(negedge clk);
    checks++;
    if (obs !== 10'b1000010001 || redirect_pc !== 64'h80000100) begin
      errors++; $display("FAIL branch_fetch_release got %b/%h want 1000010001/80000100", obs, redirect_pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL branch_fetch_run got %b want 0", obs);
    end
    tick();
  endtask

  task automatic test_trap_over_mem();
    do_reset();
    trap_req = 1; trap_vec = 64'h80000004; mem_busy = 1; ex_redirect = 1; ex_target = 64'h80000100;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0000011111 || redirect_pc !== 64'h80000004) begin
      errors++; $display("FAIL trap_over_mem got %b/%h want 0000011111/80000004", obs, redirect_pc);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_stall();
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 10'b1111000010) begin
        errors++; $display("FAIL mem_stall%0d got %b want 1111000010", i, obs);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 4) begin
      errors++; $display("FAIL mem_stall_count got %0d want 4", stall_cycles);
    end
    // reset landing in the middle of a memory stall
    do_reset();
    mem_busy = 1;
    tick(); tick();
    rstn = 0;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0000011110) begin
      errors++; $display("FAIL mem_stall_reset got %b want 0000011110", obs);
    end
    tick();
    rstn = 1;
    checks++;
    if (stall_cycles !== 0 || redirect_cnt !== 0) begin
      errors++; $display("FAIL mem_stall_reset_cnt got %0d/%0d want 0/0", stall_cycles, redirect_cnt);
    end
    @(negedge clk);
    checks++;
    if (obs !== 10'b1111000010) begin
      errors++; $display("FAIL mem_stall_after_reset got %b want 1111000010", obs);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [9:0]  ev;
    logic [63:0] ep;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rstn        = ($urandom_range(0, 59) != 0);
      if_busy     = ($urandom_range(0, 9) < 4);
      mem_busy    = ($urandom_range(0, 9) < 2);
      trap_req    = ($urandom_range(0, 19) == 0);
      ex_redirect = ($urandom_range(0, 9) < 2);
      ex_valid    = $urandom_range(0, 1);
      ex_is_load  = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1);
      id_use_rs2  = $urandom_range(0, 1);
      ex_target   = {$urandom, $urandom};
      trap_vec    = {$urandom, $urandom};
      @(negedge clk);
      model_outs(ev, ep);
      checks++;
      if (obs !== ev || redirect_pc !== ep) begin
        errors++; $display("FAIL random_outs cyc %0d got %b/%h want %b/%h", n, obs, redirect_pc, ev, ep);
      end
      tick();
      checks++;
      if (stall_cycles !== m_stalls[CNT_W-1:0] || redirect_cnt !== m_redirs[CNT_W-1:0]) begin
        errors++; $display("FAIL random_counters cyc %0d got %0d/%0d want %0d/%0d",
                           n, stall_cycles, redirect_cnt, m_stalls, m_redirs);
      end
    end
    idle_inputs();
    rstn = 1;
  endtask

  initial begin
    m_wait = 0; m_pend = '0; m_stalls = 0; m_redirs = 0;
    idle_inputs();
    rstn = 0;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_branch_fetch();
    test_trap_over_mem();
    test_mem_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
